// File: rtl/opcode_sequencer.sv
// opcode_sequencer: stores a small program of 12-bit control words and
// issues them in order to the control stage, each held HOLD_CYCLES cycles.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   prog_we/addr/data program load port (accepted in IDLE and DONE only)
//   start, stop       begin execution at address 0 / abort execution
//   opcode            registered control word (NOP when nothing issued)
//   opcode_valid      a program word is on opcode
//   pc                address of the word currently issued
//   busy              high in ISSUE
//   done              one-cycle pulse on HALT or end of memory
module opcode_sequencer #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [11:0]       prog_data,
  input  logic              start,
  input  logic              stop,
  output logic [11:0]       opcode,
  output logic              opcode_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  localparam logic [11:0] NOP  = 12'h030;
  localparam logic [11:0] HALT = 12'hFFF;

  localparam logic [3:0] HOLD_LAST =
    4'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_PC =
    ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [11:0] mem [DEPTH];

  logic [3:0]        cnt;
  logic [3:0]        cnt_nx;
  logic [11:0]       op_nx;
  logic              valid_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic [ADDR_W-1:0] pc_inc;

  logic go;
  logic last_hold;
  logic at_end;
  logic next_halt;
  logic first_halt;

  assign pc_inc     = pc + ADDR_W'(1);
  assign go         = start && !stop;
  assign last_hold  = (cnt == HOLD_LAST);
  assign at_end     = (pc == LAST_PC);
  // pc_inc wraps at the last address, but at_end
  // is checked first, so the wrapped read is unused.
  assign next_halt  = (mem[pc_inc] == HALT);
  assign first_halt = (mem[0] == HALT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; stop outranks start and fetch
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (go) begin
          state_nx = first_halt ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (stop) begin
          state_nx = S_IDLE;
        end else if (last_hold
                     && (at_end || next_halt)) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output / datapath next values
  always_comb begin
    op_nx    = opcode;
    valid_nx = opcode_valid;
    pc_nx    = pc;
    cnt_nx   = cnt;
    unique case (state)
      S_IDLE: begin
        if (go) begin
          pc_nx  = '0;
          cnt_nx = '0;
          // A HALT at address 0 is never shown
          if (!first_halt) begin
            op_nx    = mem[0];
            valid_nx = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (stop) begin
          op_nx    = NOP;
          valid_nx = 1'b0;
          cnt_nx   = '0;
        end else if (last_hold) begin
          cnt_nx = '0;
          if (at_end || next_halt) begin
            op_nx    = NOP;
            valid_nx = 1'b0;
          end else begin
            pc_nx = pc_inc;
            op_nx = mem[pc_inc];
          end
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_DONE: begin
        op_nx    = NOP;
        valid_nx = 1'b0;
      end
      default: begin
        op_nx    = NOP;
        valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode       <= NOP;
      opcode_valid <= 1'b0;
      pc           <= '0;
      cnt          <= '0;
    end else begin
      opcode       <= op_nx;
      opcode_valid <= valid_nx;
      pc           <= pc_nx;
      cnt          <= cnt_nx;
    end
  end

  // Program memory; a same-edge start reads
  // the old contents of mem[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= HALT;
      end
    end else if (prog_we && state != S_ISSUE) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign busy = (state == S_ISSUE);
  assign done = (state == S_DONE);

endmodule
